// File: rtl/exec_pkg.sv
// Shared types for the exec_unit slice: operation/shift encodings, FSM states, default width.
package exec_pkg;
    localparam int DEFAULT_DW = 16;

    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_MVN = 2'b11} op_e;
    typedef enum logic [1:0] {SH_NONE = 2'b00, SH_LSL1 = 2'b01, SH_LSR1 = 2'b10, SH_ASR1 = 2'b11} shift_e;
    typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_READ_A = 3'd1, ST_READ_B = 3'd2,
                              ST_EXEC = 3'd3, ST_WB = 3'd4} state_e;
endpackage

// File: rtl/exec_unit_alu_shift.sv
// Combinational barrel-of-one shifter on B, ALU and (with EXEC_STATUS_FLAGS_EN) {N,Z,V} flags.
module alu_shift
    import exec_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  op_e           op,
    input  shift_e        shift,
`ifdef EXEC_STATUS_FLAGS_EN
    output logic [2:0]    flags,
`endif
    output logic [DW-1:0] y
);
    logic [DW-1:0] b_sh;

    always_comb begin
        b_sh = b;
        case (shift)
            SH_NONE: b_sh = b;
            SH_LSL1: b_sh = {b[DW-2:0], 1'b0};
            SH_LSR1: b_sh = {1'b0, b[DW-1:1]};
            SH_ASR1: b_sh = {b[DW-1], b[DW-1:1]};
            default: b_sh = b;
        endcase
    end

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b_sh;
            OP_SUB:  y = a - b_sh;
            OP_AND:  y = a & b_sh;
            OP_MVN:  y = ~b_sh;
            default: y = '0;
        endcase
    end

`ifdef EXEC_STATUS_FLAGS_EN
    logic v;
    // Overflow: operands agree in sign (after negation for SUB) but the result does not.
    always_comb begin
        v = 1'b0;
        case (op)
            OP_ADD:  v = (a[DW-1] == b_sh[DW-1]) && (y[DW-1] != a[DW-1]);
            OP_SUB:  v = (a[DW-1] != b_sh[DW-1]) && (y[DW-1] != a[DW-1]);
            default: v = 1'b0;
        endcase
    end
    assign flags = {y[DW-1], (y == '0), v};
`endif
endmodule

// File: rtl/exec_unit.sv
// Multi-cycle register-file execute unit: read A, read B, execute, write back.
// Optional status flags enabled by defining EXEC_STATUS_FLAGS_EN.
module exec_unit
    import exec_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [1:0]    shift,
    input  logic [2:0]    rn,
    input  logic [2:0]    rm,
    input  logic [2:0]    rd,
    output logic [2:0]    rf_readnum,
    input  logic [DW-1:0] rf_data_out,
    output logic          rf_write,
    output logic [2:0]    rf_writenum,
    output logic [DW-1:0] rf_data_in,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic [2:0]    status
);
    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] READ_A = ST_READ_A;
    localparam logic [2:0] READ_B = ST_READ_B;
    localparam logic [2:0] EXEC   = ST_EXEC;
    localparam logic [2:0] WB     = ST_WB;

    logic [2:0]    state;
    op_e           op_q;
    shift_e        shift_q;
    logic [2:0]    rn_q, rm_q, rd_q;
    logic [DW-1:0] a_q, b_q, c_q;
    logic [DW-1:0] alu_y;

`ifdef EXEC_STATUS_FLAGS_EN
    logic [2:0] alu_flags;
    logic [2:0] status_q;
`endif

    alu_shift #(.DW(DW)) u_alu (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .shift (shift_q),
`ifdef EXEC_STATUS_FLAGS_EN
        .flags (alu_flags),
`endif
        .y     (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_ADD;
            shift_q <= SH_NONE;
            rn_q    <= '0;
            rm_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q    <= op_e'(op);
                    shift_q <= shift_e'(shift);
                    rn_q    <= rn;
                    rm_q    <= rm;
                    rd_q    <= rd;
                    state   <= READ_A;
                end
                READ_A: begin
                    a_q   <= rf_data_out;
                    state <= READ_B;
                end
                READ_B: begin
                    b_q   <= rf_data_out;
                    state <= EXEC;
                end
                EXEC: begin
                    c_q   <= alu_y;
                    state <= WB;
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXEC_STATUS_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             status_q <= '0;
        else if (state == EXEC) status_q <= alu_flags;
    end
    assign status = status_q;
`else
    assign status = 3'b000;
`endif

    // Outputs decode from state so an async reset clears them without waiting for a clock.
    assign busy        = (state != IDLE);
    assign done        = (state == WB);
    assign rf_write    = done;
    assign rf_writenum = done ? rd_q : 3'd0;
    assign rf_data_in  = done ? c_q : '0;
    assign rf_readnum  = (state == READ_A) ? rn_q : (state == READ_B) ? rm_q : 3'd0;
    assign result      = c_q;
endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases plus randomized instructions vs a reference model.
module tb_exec_unit;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = '0, shift = '0;
    logic [2:0]    rn = '0, rm = '0, rd = '0;
    logic [2:0]    rf_readnum;
    logic [DW-1:0] rf_data_out;
    logic          rf_write;
    logic [2:0]    rf_writenum;
    logic [DW-1:0] rf_data_in;
    logic          busy, done;
    logic [DW-1:0] result;
    logic [2:0]    status;

    exec_unit #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .shift(shift),
        .rn(rn), .rm(rm), .rd(rd), .rf_readnum(rf_readnum), .rf_data_out(rf_data_out),
        .rf_write(rf_write), .rf_writenum(rf_writenum), .rf_data_in(rf_data_in),
        .busy(busy), .done(done), .result(result), .status(status)
    );

    always #5 clk = ~clk;

    // Register file attached to the DUT, with a bench-side load port for preloading.
    logic [DW-1:0] rf [8];
    logic          load_en = 1'b0;
    logic [2:0]    load_idx = '0;
    logic [DW-1:0] load_val = '0;
    int            wr_cnt = 0;

    assign rf_data_out = rf[rf_readnum];

    always @(posedge clk) begin
        if (load_en)       rf[load_idx] <= load_val;
        else if (rf_write) rf[rf_writenum] <= rf_data_in;
        if (rf_write) wr_cnt <= wr_cnt + 1;
    end

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] ref_rf [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic on integers in the 0..65535 / signed-range domain.
    task automatic model(input int o, input int sh, input int a, input int b,
                         output logic [DW-1:0] y, output logic [2:0] st);
        int bs, sa, sb, r, yi;
        bit v;
        case (sh)
            0:       bs = b;
            1:       bs = (b * 2) % 65536;
            2:       bs = b / 2;
            default: bs = b / 2 + ((b >= 32768) ? 32768 : 0);
        endcase
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (bs >= 32768) ? bs - 65536 : bs;
        v = 1'b0;
        case (o)
            0: begin r = sa + sb; v = (r > 32767) || (r < -32768); yi = (a + bs) % 65536; end
            1: begin r = sa - sb; v = (r > 32767) || (r < -32768); yi = (a - bs + 65536) % 65536; end
            2: yi = a & bs;
            default: yi = 65535 - bs;
        endcase
        y = yi[DW-1:0];
`ifdef EXEC_STATUS_FLAGS_EN
        st = {yi >= 32768, yi == 0, v};
`else
        st = 3'b000;
`endif
    endtask

    // Starts and ends on a falling edge.
    task automatic set_reg(input logic [2:0] idx, input logic [DW-1:0] val);
        load_en = 1'b1; load_idx = idx; load_val = val;
        ref_rf[idx] = val;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Issues one instruction at a falling edge (cycle 0) and checks every cycle through cycle 5.
    task automatic run_instr(input int o, input int sh, input logic [2:0] s_n,
                             input logic [2:0] s_m, input logic [2:0] d);
        logic [DW-1:0] ey;
        logic [2:0]    es;
        model(o, sh, int'(ref_rf[s_n]), int'(ref_rf[s_m]), ey, es);
        chk("c0_busy", busy, 0);
        op = o[1:0]; shift = sh[1:0]; rn = s_n; rm = s_m; rd = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("c1_readnum", rf_readnum, s_n);
        chk("c1_busy", busy, 1);
        @(negedge clk);
        chk("c2_readnum", rf_readnum, s_m);
        @(negedge clk);
        chk("c3_write", rf_write, 0);
        chk("c3_readnum", rf_readnum, 0);
        @(negedge clk);
        chk("c4_write", rf_write, 1);
        chk("c4_writenum", rf_writenum, d);
        chk("c4_data", rf_data_in, ey);
        chk("c4_done", done, 1);
        ref_rf[d] = ey;
        @(negedge clk);
        chk("c5_done", done, 0);
        chk("c5_busy", busy, 0);
        chk("c5_result", result, ey);
        chk("c5_status", status, es);
        chk("c5_rf", rf[d], ey);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Reset state
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_write", rf_write, 0);
        chk("rst_result", result, 0);
        chk("rst_status", status, 0);
        chk("rst_readnum", rf_readnum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) set_reg(i[2:0], '0);

        // ADD 5+3 -> R3
        set_reg(3'd1, 16'd5);
        set_reg(3'd2, 16'd3);
        run_instr(0, 0, 3'd1, 3'd2, 3'd3);
        chk("add_r3", rf[3], 16'd8);
        chk("add_status", status, 3'b000);

        // SUB to zero, then signed-overflow SUB
        set_reg(3'd1, 16'd3);
        set_reg(3'd2, 16'd3);
        run_instr(1, 0, 3'd1, 3'd2, 3'd3);
        chk("sub0_r3", rf[3], 16'd0);
`ifdef EXEC_STATUS_FLAGS_EN
        chk("sub0_status", status, 3'b010);
`else
        chk("sub0_status", status, 3'b000);
`endif
        set_reg(3'd1, 16'h7FFF);
        set_reg(3'd2, 16'hFFFF);
        run_instr(1, 0, 3'd1, 3'd2, 3'd3);
        chk("subv_r3", rf[3], 16'h8000);
`ifdef EXEC_STATUS_FLAGS_EN
        chk("subv_status", status, 3'b101);
`else
        chk("subv_status", status, 3'b000);
`endif

        // MVN with ASR1
        set_reg(3'd2, 16'h8002);
        run_instr(3, 3, 3'd1, 3'd2, 3'd4);
        chk("mvn_r4", rf[4], 16'h3FFE);

        // rd == rn: sources read before write
        set_reg(3'd1, 16'd2);
        set_reg(3'd2, 16'd2);
        run_instr(0, 0, 3'd1, 3'd2, 3'd1);
        chk("alias_r1", rf[1], 16'd4);

        // start held high: accepts only in cycles 0, 5, 10
        base = wr_cnt;
        op = 2'b00; shift = 2'b00; rn = 3'd1; rm = 3'd2; rd = 3'd5; start = 1'b1;
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("hold_busy_%0d", k), busy, (k % 5) != 0);
            chk($sformatf("hold_done_%0d", k), done, (k % 5) == 4);
            @(negedge clk);
        end
        start = 1'b0;
        ref_rf[5] = 16'd6;
        chk("hold_writes", wr_cnt - base, 3);
        chk("hold_r5", rf[5], 16'd6);
        chk("hold_idle", busy, 0);

        // Reset asserted during EXEC aborts the write
        set_reg(3'd6, 16'h1234);
        base = wr_cnt;
        op = 2'b00; shift = 2'b00; rn = 3'd1; rm = 3'd2; rd = 3'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_exec", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_write", rf_write, 0);
        chk("abort_writenum", rf_writenum, 0);
        chk("abort_data_in", rf_data_in, 0);
        chk("abort_readnum", rf_readnum, 0);
        chk("abort_result", result, 0);
        chk("abort_status", status, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_write", wr_cnt - base, 0);
        chk("abort_r6", rf[6], 16'h1234);
        run_instr(0, 1, 3'd1, 3'd2, 3'd6);

        // Randomized instructions
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1)
                set_reg(3'($urandom_range(0, 7)), 16'($urandom));
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter DW, default 16, meaning data width of the register file words.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to execute one instruction.
REQ-005 SHALL have port op, input, 2, operation: 00 ADD, 01 SUB, 10 AND, 11 MVN.
REQ-006 SHALL have port shift, input, 2, shift on B operand: 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
REQ-007 SHALL have ports rn, rm, rd, input, 3 each: source A, source B and destination register indices.
REQ-008 SHALL have port rf_readnum, output, 3, read index to the register file.
REQ-009 SHALL have port rf_data_out, input, DW, combinational read data from the register file.
REQ-010 SHALL have ports rf_write (output, 1), rf_writenum (output, 3) and rf_data_in (output, DW): the write port to the register file.
REQ-011 SHALL have ports busy (output, 1), done (output, 1), result (output, DW) and status (output, 3, {N,Z,V}).

Function
REQ-012 SHALL implement FSM IDLE, READ_A, READ_B, EXEC, WB; transitions IDLE->READ_A on start=1, then unconditional READ_A->READ_B->EXEC->WB->IDLE.
REQ-013 SHALL latch op, shift, rn, rm and rd on the IDLE edge where start=1; start in any other state is ignored, with no queuing.
REQ-014 SHALL drive rf_readnum=rn in READ_A, rm in READ_B and 0 otherwise, and capture rf_data_out into register A (READ_A) or register B (READ_B) at the end of that cycle.
REQ-015 SHALL, at the end of EXEC, load register C with the op result over (A, shifted B), all DW-bit arithmetic modulo 2^DW. MVN = ~shifted B. ASR1 replicates the MSB.
REQ-016 SHALL, in WB, assert rf_write=1, rf_writenum=rd, rf_data_in=C and done=1 for exactly one cycle; in all other states these are 0.
REQ-017 SHALL assert busy in every state except IDLE, and hold result=C until the next EXEC.
REQ-018 SHALL take fixed latency: start sampled in cycle 0, WB in cycle 4, IDLE in cycle 5 (earliest next accept).
REQ-019 SHALL read both sources before writing, so rd equal to rn and/or rm yields the pre-write operand values.

Reset
REQ-020 SHALL, on rst_n=0 at any time including mid-instruction, immediately force state IDLE and clear A, B, C, status, result, busy, done, rf_write, rf_writenum, rf_readnum and rf_data_in to 0; the aborted instruction issues no write.

Configuration
REQ-021 SHALL, with EXEC_STATUS_FLAGS_EN defined, update status at the end of EXEC: N=C[DW-1], Z=(C==0), V=signed overflow for ADD/SUB, and V=0 for AND/MVN.
REQ-022 SHALL, without EXEC_STATUS_FLAGS_EN, tie status to 3'b000 and include no flag registers.

Structure
REQ-023 SHALL place the op enum, shift enum, FSM state enum and default width constant in shared package exec_pkg.
REQ-024 SHALL contain one combinational sub-module, alu_shift, that computes the shifted B, the op result and the flags; the FSM and registers stay in exec_unit.

Verification
REQ-025 SHALL check: R1=5, R2=3, ADD rn=1 rm=2 rd=3 shift=00 -> WB in cycle 4 writes 8 to rd 3, done one cycle, status {0,0,0}.
REQ-026 SHALL check: R1=3, R2=3, SUB -> C=0, status Z=1; R1=16'h7FFF, R2=16'hFFFF, SUB -> C=16'h8000, N=1, V=1 (flags macro on); all zero with macro off.
REQ-027 SHALL check: R2=16'h8002, MVN shift=11 (ASR1) rd=4 -> shifted B=16'hC001, write 16'h3FFE to R4.
REQ-028 SHALL check: start held high continuously -> instructions accepted only in cycles 0, 5, 10; busy low only in accept cycles.
REQ-029 SHALL check: rst_n pulled low in EXEC -> rf_write never asserted, all outputs 0 asynchronously, and the next start after release executes normally.
REQ-030 SHALL check: ADD rn=rd=1 with R1=2, R2=2 -> R1 becomes 4; reads observed at rf_readnum 1 then 2.
